// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver, 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit)
//
// The serial line is oversampled at 16x baud using a clock-enable tick derived
// from the system clock; no other clocks are generated. Each start edge arms a
// mid-bit sampling schedule, so every later sample lands near the centre of
// its bit.
//
// Parameters
//   clk_freq   system clock frequency in Hz
//   baud_rate  line rate in bit/s; clk_freq/(baud_rate*16) must be >= 2
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   rx       in   serial input, asynchronous to clk, idles high
//   rx_data  out  last good received byte
//   donerx   out  one-clk pulse: rx_data updated with a good frame
//   ferr     out  one-clk pulse: stop bit sampled low, byte discarded
//   busy     out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       donerx,
    output logic       ferr,
    output logic       busy
);

    localparam int DIV = clk_freq / (baud_rate * 16);
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [3:0]    scnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;

    // Two-flop synchronizer. Both stages reset to the idle level so that
    // leaving reset never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running 16x baud clock enable.
    assign tick = (tcnt == TICK_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Receive FSM. All decisions are taken on tick cycles only; scnt counts
    // ticks within the current state and is cleared on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            scnt    <= '0;
            bidx    <= '0;
            shreg   <= '0;
            rx_data <= '0;
            donerx  <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle and are raised only on
            // the deciding tick, which guarantees single-clock pulses.
            donerx <= 1'b0;
            ferr   <= 1'b0;

            if (tick) begin
                scnt <= scnt + 4'd1;

                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            busy  <= 1'b1;
                            scnt  <= '0;
                        end
                    end

                    // Half a bit after the edge: a line that is high again
                    // was only a glitch.
                    ST_START: begin
                        if (scnt == 4'd7) begin
                            scnt <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                                bidx  <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end

                    // From mid start bit, 16 ticks reach mid of each data bit.
                    // Within DATA, scnt wraps 15 -> 0 on its own.
                    ST_DATA: begin
                        if (scnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            if (bidx == 3'd7) begin
                                state <= ST_STOP;
                                scnt  <= '0;
                            end else begin
                                bidx <= bidx + 3'd1;
                            end
                        end
                    end

                    // IDLE is re-entered on the stop-sample tick so a start
                    // edge immediately following the stop bit is accepted.
                    ST_STOP: begin
                        if (scnt == 4'd15) begin
                            scnt <= '0;
                            if (rx_s) begin
                                rx_data <= shreg;
                                donerx  <= 1'b1;
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                ferr  <= 1'b1;
                                state <= ST_BREAK;
                            end
                        end
                    end

                    // Wait out a held-low line so it produces a single ferr.
                    ST_BREAK: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            scnt  <= '0;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        scnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx
//
// A frame-level model predicts the DUT outputs on every clock: it tracks the
// tick phase from the clock count since reset, schedules the mid-bit sample
// instants of each frame from the start-detect tick, and derives donerx, ferr,
// busy and rx_data from those samples. Directed tests add literal
// expectations on byte values and pulse counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 9600;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       donerx;
    logic       ferr;
    logic       busy;

    uart_rx #(
        .clk_freq (CLK_FREQ),
        .baud_rate(BAUD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_data(rx_data),
        .donerx (donerx),
        .ferr   (ferr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int         m_cyc;
    bit         m_h1, m_h2;
    bit         m_in_frame, m_in_break;
    int         m_t0;
    logic [7:0] m_byte;
    logic [7:0] m_data;
    bit         m_done, m_ferr;
    int         done_cnt = 0;
    int         ferr_cnt = 0;

    initial begin : model_compare
        m_cyc      = 0;
        m_h1       = 1'b1;
        m_h2       = 1'b1;
        m_in_frame = 1'b0;
        m_in_break = 1'b0;
        m_t0       = 0;
        m_byte     = 8'h00;
        m_data     = 8'h00;
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            m_ferr = 1'b0;
            if (!rst) begin
                m_cyc      = 0;
                m_h1       = 1'b1;
                m_h2       = 1'b1;
                m_in_frame = 1'b0;
                m_in_break = 1'b0;
                m_data     = 8'h00;
            end else begin
                bit line;
                // Line value seen by the receiver: rx from two edges ago.
                line  = m_h2;
                m_h2  = m_h1;
                m_h1  = rx;
                m_cyc = m_cyc + 1;
                if (m_cyc % DIV == 0) begin
                    if (m_in_frame) begin
                        int k;
                        k = (m_cyc - m_t0) / DIV;
                        if (k == 8 && line) begin
                            m_in_frame = 1'b0;
                        end else if (k > 8 && k < 152 && (k - 8) % 16 == 0) begin
                            m_byte[(k - 8) / 16 - 1] = line;
                        end else if (k == 152) begin
                            m_in_frame = 1'b0;
                            if (line) begin
                                m_done = 1'b1;
                                m_data = m_byte;
                            end else begin
                                m_ferr     = 1'b1;
                                m_in_break = 1'b1;
                            end
                        end
                    end else if (m_in_break) begin
                        if (line) m_in_break = 1'b0;
                    end else if (!line) begin
                        m_in_frame = 1'b1;
                        m_t0       = m_cyc;
                    end
                end
            end
            #1;
            check("donerx", donerx, m_done);
            check("ferr", ferr, m_ferr);
            check("busy", busy, m_in_frame || m_in_break);
            check("rx_data", rx_data, m_data);
            if (donerx === 1'b1) done_cnt++;
            if (ferr === 1'b1) ferr_cnt++;
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(b[i], BIT_CLKS);
        drive(stop, BIT_CLKS);
    endtask

    int d0, f0;

    initial begin : stimulus
        repeat (3) @(negedge clk);

        // 1. reset and idle line
        check("t1 busy in reset", busy, 1'b0);
        rst = 1'b1;
        drive(1'b1, 2 * BIT_CLKS);
        check("t1 busy", busy, 1'b0);
        check("t1 rx_data", rx_data, 8'h00);
        check("t1 donerx count", done_cnt, 0);
        check("t1 ferr count", ferr_cnt, 0);

        // 2. single byte
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'hA5, 1'b1);
        drive(1'b1, 2 * BIT_CLKS);
        check("t2 donerx count", done_cnt - d0, 1);
        check("t2 ferr count", ferr_cnt - f0, 0);
        check("t2 rx_data", rx_data, 8'hA5);

        // 3. back-to-back frames, no idle gap
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'h00, 1'b1);
        check("t3 first donerx count", done_cnt - d0, 1);
        check("t3 first rx_data", rx_data, 8'h00);
        send(8'hFF, 1'b1);
        drive(1'b1, 2 * BIT_CLKS);
        check("t3 donerx count", done_cnt - d0, 2);
        check("t3 ferr count", ferr_cnt - f0, 0);
        check("t3 second rx_data", rx_data, 8'hFF);

        // 4. short glitch is rejected
        d0 = done_cnt; f0 = ferr_cnt;
        drive(1'b0, 3 * DIV);
        drive(1'b1, 2 * BIT_CLKS);
        check("t4 donerx count", done_cnt - d0, 0);
        check("t4 ferr count", ferr_cnt - f0, 0);
        check("t4 rx_data", rx_data, 8'hFF);
        check("t4 busy", busy, 1'b0);

        // 5. bad stop bit, held-low line, then recovery
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'h3C, 1'b0);
        drive(1'b0, 3 * BIT_CLKS);
        check("t5 busy in break", busy, 1'b1);
        drive(1'b1, 2 * BIT_CLKS);
        check("t5 ferr count", ferr_cnt - f0, 1);
        check("t5 donerx count", done_cnt - d0, 0);
        check("t5 rx_data kept", rx_data, 8'hFF);
        d0 = done_cnt;
        send(8'h5A, 1'b1);
        drive(1'b1, 2 * BIT_CLKS);
        check("t5 next donerx count", done_cnt - d0, 1);
        check("t5 next rx_data", rx_data, 8'h5A);

        // 6. reset during data bit 4 of 8'hC3
        d0 = done_cnt; f0 = ferr_cnt;
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(logic'((8'hC3 >> i) & 8'h01), BIT_CLKS);
        drive(1'b0, BIT_CLKS / 2);
        check("t6 busy before reset", busy, 1'b1);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("t6 busy in reset", busy, 1'b0);
        check("t6 donerx in reset", donerx, 1'b0);
        check("t6 ferr in reset", ferr, 1'b0);
        check("t6 rx_data in reset", rx_data, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2 * BIT_CLKS);
        check("t6 no pulse after abort", done_cnt - d0, 0);
        send(8'h81, 1'b1);
        drive(1'b1, 2 * BIT_CLKS);
        check("t6 donerx count", done_cnt - d0, 1);
        check("t6 ferr count", ferr_cnt - f0, 0);
        check("t6 rx_data", rx_data, 8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
